// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier: one (N+1)-bit multiplying adder iterated N times,
// with a start/ready request handshake and a one-cycle done pulse carrying the 2N-bit product.
module seq_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     mult_q, mult_d;
  logic [N:0]       acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   p_q, p_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [N:0]       sum;

  function automatic logic [N:0] mul_add(input logic [N:0] x, input logic [N:0] y,
                                         input logic m);
    return x + (m ? y : '0);
  endfunction

  // acc_q[N] is always zero after the shift, so acc_q equals {1'b0, acc_q[N-1:0]}.
  assign sum = mul_add(acc_q, {1'b0, mcand_q}, mult_q[0]);

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mult_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d  = {1'b0, sum[N:1]};
        mult_d = {sum[0], mult_q[N-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          p_d     = {sum, mult_q[N-1:1]};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign p     = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a cycle-level transaction model for N=4 plus directed N=8 checks.
module tb_seq_multiplier;

  localparam int N4 = 4;
  localparam int N8 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, done4;
  logic [7:0]  p4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, done8;
  logic [15:0] p8;

  seq_multiplier #(.N(N4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .done(done4), .p(p4)
  );

  seq_multiplier #(.N(N8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .p(p8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: phase 0 is idle, phases 1..N busy, phase N+1 is the done cycle.
  int ph = 0;
  int pend = 0;
  int p_exp = 0;
  int n_done_exp = 0;
  int n_done_seen = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= 0;
      pend  <= 0;
      p_exp <= 0;
    end else if (ph == 0) begin
      if (start4) begin
        ph   <= 1;
        pend <= int'(a4) * int'(b4);
      end
    end else if (ph == N4 + 1) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
      if (ph == N4) begin
        p_exp      <= pend;
        n_done_exp <= n_done_exp + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check_eq("ready4", ready4, (ph == 0));
      check_eq("done4", done4, (ph == N4 + 1));
      check_eq("p4", p4, p_exp);
      if (done4) n_done_seen++;
    end
  end

  task automatic wait_ready4();
    int k = 0;
    while (!ready4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready4_wait", ready4, 1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int k = 0;
    wait_ready4();
    a4 = a;
    b4 = b;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("done4_wait", done4, 1);
    @(negedge clk);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    while (!ready8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready8_wait", ready8, 1);
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check_eq("ready8_drop", ready8, 0);
    k = 1;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("lat8", k, N8 + 1);
    check_eq("p8", p8, int'(a) * int'(b));
    @(negedge clk);
    check_eq("done8_pulse", done8, 0);
    check_eq("p8_hold", p8, int'(a) * int'(b));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready4", ready4, 1);
    check_eq("rst_done4", done4, 0);
    check_eq("rst_p4", p4, 0);
    check_eq("rst_ready8", ready8, 1);
    check_eq("rst_p8", p8, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Directed N=4 cases
    op4(4'd3, 4'd5);
    check_eq("p_3x5", p4, 15);
    op4(4'd15, 4'd15);
    check_eq("p_15x15", p4, 225);
    op4(4'd0, 4'd9);
    check_eq("p_0x9", p4, 0);
    op4(4'd9, 4'd0);
    check_eq("p_9x0", p4, 0);

    // Exhaustive N=4 with random idle gaps
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        op4(i[3:0], j[3:0]);
        check_eq("exh", p4, i * j);
      end
    end

    // Start held high with operands changing every cycle
    wait_ready4();
    start4 = 1'b1;
    repeat (40) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      @(negedge clk);
    end
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    // Start pulsed while busy must be ignored
    wait_ready4();
    a4 = 4'd2;
    b4 = 4'd3;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 4'd15;
    b4 = 4'd15;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("p_busy_ignore", p4, 6);

    // Asynchronous reset two cycles into an operation
    wait_ready4();
    a4 = 4'd7;
    b4 = 4'd6;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ready4", ready4, 1);
    check_eq("arst_done4", done4, 0);
    check_eq("arst_p4", p4, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    op4(4'd10, 4'd11);
    check_eq("p_10x11", p4, 110);

    // N=8 cases
    op8(8'd255, 8'd255);
    op8(8'd128, 8'd2);
    op8(8'($urandom), 8'($urandom));

    repeat (4) @(negedge clk);
    check_eq("done_count", n_done_seen, n_done_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
